// File: rtl/sdram_traffic_gen_pkg.sv
// ----------------------------------------------------------------------------
// sdram_traffic_gen_pkg : shared state encoding and sizing helper
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package sdram_traffic_gen_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WR_REQ  = 3'd1,
    S_WR_WAIT = 3'd2,
    S_RD_REQ  = 3'd3,
    S_RD_WAIT = 3'd4,
    S_CHECK   = 3'd5,
    S_DONE    = 3'd6
  } tg_state_e;

  // Register width for a counter holding 0..value-1; never narrower than 1 bit.
  function automatic int clog2_min1(input int value);
    return (value <= 2) ? 1 : $clog2(value);
  endfunction

endpackage

`default_nettype wire

// File: rtl/sdram_traffic_gen_pattern.sv
// ----------------------------------------------------------------------------
// sdram_traffic_gen_pattern : address / data pattern / word index sequencer
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module sdram_traffic_gen_pattern
  import sdram_traffic_gen_pkg::*;
#(
  parameter int          ADDR_W      = 24,
  parameter int          DATA_W      = 16,
  parameter int          NUM_WORDS   = 16,
  parameter int          ADDR_STRIDE = 1,
  parameter logic [15:0] SEED        = 16'hACE1,
  parameter logic [15:0] PATTERN_INC = 16'h0101
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_i,
  input  logic              rewind_i,
  input  logic              step_i,
  input  logic [ADDR_W-1:0] base_i,
  output logic [ADDR_W-1:0] addr_o,
  output logic [DATA_W-1:0] pat_o,
  output logic              last_o
);

  localparam int                IDX_W    = clog2_min1(NUM_WORDS);
  localparam logic [DATA_W-1:0] SEED_V   = DATA_W'(SEED);
  localparam logic [DATA_W-1:0] INC_V    = DATA_W'(PATTERN_INC);
  localparam logic [ADDR_W-1:0] STRIDE_V = ADDR_W'(ADDR_STRIDE);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_WORDS - 1);

  logic [ADDR_W-1:0] base_q, base_d, addr_q, addr_d;
  logic [DATA_W-1:0] pat_q, pat_d;
  logic [IDX_W-1:0]  idx_q, idx_d;

  // Load captures a new base; rewind restarts from the captured base for the read phase.
  always_comb begin
    base_d = base_q;
    addr_d = addr_q;
    pat_d  = pat_q;
    idx_d  = idx_q;
    if (load_i) begin
      base_d = base_i;
      addr_d = base_i;
      pat_d  = SEED_V;
      idx_d  = '0;
    end else if (rewind_i) begin
      addr_d = base_q;
      pat_d  = SEED_V;
      idx_d  = '0;
    end else if (step_i) begin
      addr_d = addr_q + STRIDE_V;
      pat_d  = pat_q + INC_V;
      idx_d  = idx_q + IDX_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      base_q <= '0;
      addr_q <= '0;
      pat_q  <= '0;
      idx_q  <= '0;
    end else begin
      base_q <= base_d;
      addr_q <= addr_d;
      pat_q  <= pat_d;
      idx_q  <= idx_d;
    end
  end

  assign addr_o = addr_q;
  assign pat_o  = pat_q;
  assign last_o = (idx_q == LAST_IDX);

endmodule

`default_nettype wire

// File: rtl/sdram_traffic_gen.sv
// ----------------------------------------------------------------------------
// sdram_traffic_gen : write/read-back memory tester for the sdram host port
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module sdram_traffic_gen
  import sdram_traffic_gen_pkg::*;
#(
  parameter int          ADDR_W      = 24,
  parameter int          DATA_W      = 16,
  parameter int          NUM_WORDS   = 16,
  parameter int          ADDR_STRIDE = 1,
  parameter logic [15:0] SEED        = 16'hACE1,
  parameter logic [15:0] PATTERN_INC = 16'h0101,
  parameter int          TIMEOUT     = 1023,
  parameter int          CNT_W       = $clog2(NUM_WORDS + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  output logic [ADDR_W-1:0] haddr,
  output logic [DATA_W-1:0] wr_data,
  output logic              wr_enable,
  output logic              rd_enable,
  input  logic [DATA_W-1:0] rd_data,
  input  logic              busy,
  output logic              running,
  output logic              done,
  output logic              pass,
  output logic [CNT_W-1:0]  err_count,
  output logic [ADDR_W-1:0] first_err_addr,
  output logic              timeout
);

  localparam int               TO_W   = clog2_min1(TIMEOUT);
  localparam logic [TO_W-1:0]  TO_MAX = TO_W'(TIMEOUT - 1);

  tg_state_e         state_q, state_d;
  logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
  logic [CNT_W-1:0]  err_q, err_d;
  logic [ADDR_W-1:0] first_q, first_d;
  logic              pass_q, pass_d, timeout_q, timeout_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              pg_load, pg_rewind, pg_step, pg_last, wait_cycle;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] pat;

  sdram_traffic_gen_pattern #(
    .ADDR_W      (ADDR_W),
    .DATA_W      (DATA_W),
    .NUM_WORDS   (NUM_WORDS),
    .ADDR_STRIDE (ADDR_STRIDE),
    .SEED        (SEED),
    .PATTERN_INC (PATTERN_INC)
  ) u_pattern (
    .clk      (clk),
    .rst_n    (rst_n),
    .load_i   (pg_load),
    .rewind_i (pg_rewind),
    .step_i   (pg_step),
    .base_i   (base_addr),
    .addr_o   (addr),
    .pat_o    (pat),
    .last_o   (pg_last)
  );

  always_comb begin
    state_d    = state_q;
    to_cnt_d   = '0;
    err_d      = err_q;
    first_d    = first_q;
    pass_d     = pass_q;
    timeout_d  = timeout_q;
    rdata_d    = rdata_q;
    pg_load    = 1'b0;
    pg_rewind  = 1'b0;
    pg_step    = 1'b0;
    wait_cycle = 1'b0;
    case (state_q)
      S_IDLE: if (start && !busy) begin
        pg_load   = 1'b1;
        err_d     = '0;
        first_d   = '0;
        pass_d    = 1'b0;
        timeout_d = 1'b0;
        state_d   = S_WR_REQ;
      end
      S_WR_REQ:  if (busy) state_d = S_WR_WAIT; else wait_cycle = 1'b1;
      S_WR_WAIT: if (busy) wait_cycle = 1'b1;
                 else if (pg_last) begin pg_rewind = 1'b1; state_d = S_RD_REQ; end
                 else begin pg_step = 1'b1; state_d = S_WR_REQ; end
      S_RD_REQ:  if (busy) state_d = S_RD_WAIT; else wait_cycle = 1'b1;
      S_RD_WAIT: if (busy) wait_cycle = 1'b1;
                 else begin rdata_d = rd_data; state_d = S_CHECK; end
      S_CHECK: begin
        if (rdata_q != pat) begin
          if (err_q != '1) err_d = err_q + CNT_W'(1);
          if (err_q == '0) first_d = addr;
        end
        // Results settle on entry to DONE so they are valid alongside the done pulse.
        if (pg_last) begin
          pass_d  = (err_d == '0);
          state_d = S_DONE;
        end else begin
          pg_step = 1'b1;
          state_d = S_RD_REQ;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (wait_cycle) begin
      if (to_cnt_q == TO_MAX) begin
        timeout_d = 1'b1;
        pass_d    = 1'b0;
        state_d   = S_DONE;
      end else begin
        to_cnt_d = to_cnt_q + TO_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      to_cnt_q  <= '0;
      err_q     <= '0;
      first_q   <= '0;
      pass_q    <= 1'b0;
      timeout_q <= 1'b0;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      to_cnt_q  <= to_cnt_d;
      err_q     <= err_d;
      first_q   <= first_d;
      pass_q    <= pass_d;
      timeout_q <= timeout_d;
      rdata_q   <= rdata_d;
    end
  end

  assign haddr          = addr;
  assign wr_data        = pat;
  assign wr_enable      = (state_q == S_WR_REQ);
  assign rd_enable      = (state_q == S_RD_REQ);
  assign done           = (state_q == S_DONE);
  assign running        = (state_q != S_IDLE) && (state_q != S_DONE);
  assign pass           = pass_q;
  assign err_count      = err_q;
  assign first_err_addr = first_q;
  assign timeout        = timeout_q;

endmodule

`default_nettype wire

// File: tb/tb_sdram_traffic_gen.sv
// ----------------------------------------------------------------------------
// tb_sdram_traffic_gen : scoreboard bench with a behavioural sdram responder
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_sdram_traffic_gen;

  typedef struct packed {
    logic        is_rd;
    logic [23:0] addr;
    logic [15:0] data;
  } acc_t;

  typedef struct packed {
    logic        pass;
    logic [31:0] err;
    logic [23:0] first;
    logic        to;
  } res_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        start4 = 1'b0, start16 = 1'b0, sel = 1'b0;
  logic [23:0] base = '0;
  logic        busy;
  logic [15:0] rd_data;

  logic [23:0] haddr4, haddr16, first4, first16;
  logic [15:0] wdata4, wdata16;
  logic        wr4, wr16, rd4, rd16, run4, run16, done4, done16;
  logic        pass4, pass16, to4, to16;
  logic [2:0]  err4;
  logic [4:0]  err16;

  sdram_traffic_gen #(.NUM_WORDS(4)) u4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .base_addr(base),
    .haddr(haddr4), .wr_data(wdata4), .wr_enable(wr4), .rd_enable(rd4),
    .rd_data(rd_data), .busy(busy), .running(run4), .done(done4),
    .pass(pass4), .err_count(err4), .first_err_addr(first4), .timeout(to4)
  );

  sdram_traffic_gen #(.NUM_WORDS(16)) u16 (
    .clk(clk), .rst_n(rst_n), .start(start16), .base_addr(base),
    .haddr(haddr16), .wr_data(wdata16), .wr_enable(wr16), .rd_enable(rd16),
    .rd_data(rd_data), .busy(busy), .running(run16), .done(done16),
    .pass(pass16), .err_count(err16), .first_err_addr(first16), .timeout(to16)
  );

  logic [23:0] m_haddr, m_first;
  logic [15:0] m_wdata;
  logic        m_wr, m_rd, m_run, m_done, m_pass, m_to;
  logic [31:0] m_err;

  assign m_haddr = sel ? haddr16 : haddr4;
  assign m_wdata = sel ? wdata16 : wdata4;
  assign m_wr    = sel ? wr16 : wr4;
  assign m_rd    = sel ? rd16 : rd4;
  assign m_run   = sel ? run16 : run4;
  assign m_done  = sel ? done16 : done4;
  assign m_pass  = sel ? pass16 : pass4;
  assign m_to    = sel ? to16 : to4;
  assign m_first = sel ? first16 : first4;
  assign m_err   = sel ? 32'(err16) : 32'(err4);

  int checks = 0;
  int errors = 0;
  acc_t exp_q[$];
  res_t res_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Responder: busy rises 2 cycles after a request is first seen, stays high 5 cycles.
  logic        never_busy = 1'b0, corrupt_en = 1'b0, corrupt_all = 1'b0;
  logic [23:0] corrupt_addr = '0;
  logic [15:0] mem [0:255];
  logic        rsp_active, rsp_is_rd;
  logic [23:0] rsp_addr;
  int          rsp_cnt;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= 1'b0; rd_data <= '0; rsp_active <= 1'b0;
      rsp_is_rd <= 1'b0; rsp_addr <= '0; rsp_cnt <= 0;
    end else if (!rsp_active) begin
      if ((m_wr || m_rd) && !never_busy) begin
        rsp_active <= 1'b1; rsp_cnt <= 0; rsp_is_rd <= m_rd; rsp_addr <= m_haddr;
        if (m_wr) mem[m_haddr[7:0]] <= m_wdata;
      end
    end else begin
      rsp_cnt <= rsp_cnt + 1;
      if (rsp_cnt == 1) busy <= 1'b1;
      if (rsp_cnt == 6) begin
        busy <= 1'b0;
        rsp_active <= 1'b0;
        if (rsp_is_rd)
          rd_data <= mem[rsp_addr[7:0]] ^
                     {15'b0, corrupt_all || (corrupt_en && rsp_addr == corrupt_addr)};
      end
    end
  end

  // Monitor: compare each new request and each done pulse against the scoreboard.
  logic        prev_wr = 1'b0, prev_rd = 1'b0;
  logic [23:0] hold_addr = '0;
  logic [15:0] hold_data = '0;

  always @(negedge clk) begin : mon
    acc_t e;
    res_t r;
    if (!rst_n) begin
      prev_wr <= 1'b0;
      prev_rd <= 1'b0;
    end else begin
      if ((m_wr && !prev_wr) || (m_rd && !prev_rd)) begin
        check("wr_rd_exclusive", {31'b0, m_wr & m_rd}, 32'd0);
        if (exp_q.size() == 0) begin
          check("unexpected_access", {8'b0, m_haddr}, 32'hFFFFFFFF);
        end else begin
          e = exp_q.pop_front();
          check("acc_is_read", {31'b0, m_rd}, {31'b0, e.is_rd});
          check("acc_addr", {8'b0, m_haddr}, {8'b0, e.addr});
          if (!e.is_rd) check("acc_wdata", {16'b0, m_wdata}, {16'b0, e.data});
        end
        hold_addr <= m_haddr;
        hold_data <= m_wdata;
      end else if ((m_wr && prev_wr) || (m_rd && prev_rd)) begin
        check("haddr_stable", {8'b0, m_haddr}, {8'b0, hold_addr});
        if (m_wr) check("wdata_stable", {16'b0, m_wdata}, {16'b0, hold_data});
      end
      if (m_done) begin
        if (res_q.size() == 0) begin
          check("unexpected_done", 32'd1, 32'd0);
        end else begin
          r = res_q.pop_front();
          check("res_pass", {31'b0, m_pass}, {31'b0, r.pass});
          check("res_err_count", m_err, r.err);
          check("res_first_err_addr", {8'b0, m_first}, {8'b0, r.first});
          check("res_timeout", {31'b0, m_to}, {31'b0, r.to});
          check("res_running_low", {31'b0, m_run}, 32'd0);
        end
      end
      prev_wr <= m_wr;
      prev_rd <= m_rd;
    end
  end

  task automatic push_accesses(input logic [23:0] b, input int n);
    acc_t a;
    logic [15:0] d;
    logic [23:0] ad;
    for (int ph = 0; ph < 2; ph++) begin
      ad = b;
      d  = 16'hACE1;
      for (int i = 0; i < n; i++) begin
        a.is_rd = (ph == 1);
        a.addr  = ad;
        a.data  = d;
        exp_q.push_back(a);
        ad = ad + 24'd1;
        d  = d + 16'h0101;
      end
    end
  endtask

  task automatic push_res(input logic p, input int e, input logic [23:0] f, input logic t);
    res_t r;
    r.pass = p; r.err = e; r.first = f; r.to = t;
    res_q.push_back(r);
  endtask

  task automatic run_pass(input logic s, input logic [23:0] b, output int wr_hi);
    int n;
    wr_hi = 0;
    sel   = s;
    base  = b;
    @(negedge clk);
    if (s) start16 = 1'b1; else start4 = 1'b1;
    @(negedge clk);
    start16 = 1'b0;
    start4  = 1'b0;
    check("start_to_wr_enable", {31'b0, m_wr}, 32'd1);
    n = 0;
    while (!m_done && n < 4000) begin
      if (m_wr) wr_hi++;
      @(negedge clk);
      n++;
    end
    check("done_seen", {31'b0, m_done}, 32'd1);
    @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int hi;
    int n;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_haddr", {8'b0, haddr4}, 32'd0);
    check("rst_wr_data", {16'b0, wdata4}, 32'd0);
    check("rst_enables", {30'b0, wr4, rd4}, 32'd0);
    check("rst_flags", {28'b0, run4, done4, pass4, to4}, 32'd0);
    check("rst_err", {29'b0, err4}, 32'd0);
    check("rst_first", {8'b0, first4}, 32'd0);

    // Clean pass
    push_accesses(24'hfedbed, 4);
    push_res(1'b1, 0, 24'h0, 1'b0);
    run_pass(1'b0, 24'hfedbed, hi);
    check("t1_pass_sticky", {31'b0, m_pass}, 32'd1);

    // Word 2 corrupted
    corrupt_en = 1'b1; corrupt_addr = 24'hfedbef;
    push_accesses(24'hfedbed, 4);
    push_res(1'b0, 1, 24'hfedbef, 1'b0);
    run_pass(1'b0, 24'hfedbed, hi);
    corrupt_en = 1'b0;

    // Responder silent: timeout after exactly 1023 request cycles
    never_busy = 1'b1;
    push_res(1'b0, 0, 24'h0, 1'b1);
    exp_q.push_back({1'b0, 24'hfedbed, 16'hACE1});
    run_pass(1'b0, 24'hfedbed, hi);
    check("t3_wr_cycles", hi, 32'd1023);
    check("t3_wr_dropped", {31'b0, m_wr}, 32'd0);
    check("t3_timeout_sticky", {31'b0, m_to}, 32'd1);
    never_busy = 1'b0;
    push_accesses(24'hfedbed, 4);
    push_res(1'b1, 0, 24'h0, 1'b0);
    run_pass(1'b0, 24'hfedbed, hi);

    // Address wrap
    push_accesses(24'hfffffe, 4);
    push_res(1'b1, 0, 24'h0, 1'b0);
    run_pass(1'b0, 24'hfffffe, hi);

    // Restart ignored mid-pass, then async reset during a read
    push_accesses(24'hfedbed, 4);
    base = 24'hfedbed;
    @(negedge clk); start4 = 1'b1;
    @(negedge clk); start4 = 1'b0;
    repeat (10) @(negedge clk);
    base = 24'h000040;
    start4 = 1'b1;
    @(negedge clk); start4 = 1'b0;
    n = 0;
    while (!m_rd && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("t5_read_reached", {31'b0, m_rd}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("t5_rst_enables", {30'b0, wr4, rd4}, 32'd0);
    check("t5_rst_flags", {28'b0, run4, done4, pass4, to4}, 32'd0);
    check("t5_rst_haddr", {8'b0, haddr4}, 32'd0);
    exp_q.delete();
    res_q.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    push_accesses(24'hfedbed, 4);
    push_res(1'b1, 0, 24'h0, 1'b0);
    run_pass(1'b0, 24'hfedbed, hi);

    // Every read corrupted on the 16-word instance
    corrupt_all = 1'b1;
    push_accesses(24'h000100, 16);
    push_res(1'b0, 16, 24'h000100, 1'b0);
    run_pass(1'b1, 24'h000100, hi);
    corrupt_all = 1'b0;

    repeat (3) @(negedge clk);
    check("scoreboard_drained", exp_q.size() + res_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
